// File: rtl/mmc_pkg.sv
// Shared definitions for the MMC CMD-line controller: state encoding, frame
// geometry and the CRC7 step used by both the transmit and receive paths.
package mmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_t;

  localparam int FRAME_W   = 48;
  localparam int PAYLOAD_W = 40;  // bits [47:8], covered by CRC7
  localparam int START_POS = 47;
  localparam int TRANS_POS = 46;
  localparam int CRC_LSB   = 1;
  localparam int END_POS   = 0;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    crc7_step = {crc[5:0], 1'b0} ^ (((din ^ crc[6]) == 1'b1) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/mmc_crc7.sv
// Serial CRC7 accumulator, MSB-first; clear has priority over enable.
module mmc_crc7
  import mmc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // Accumulate one bit per enabled cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc7_step(crc, din);
    end
  end

endmodule

// File: rtl/mmc_cmd_ctrl.sv
// MMC CMD-line sequencer: sends a 48-bit command frame with CRC7, optionally
// collects a 48-bit response, then holds the line released for NCC ticks.
// Optional macro MMC_CMD_RESP_CRC_EN enables CRC7 checking of the response.
module mmc_cmd_ctrl
  import mmc_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmc_tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_resp_en,
  output logic        resp_valid,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        resp_crc_err,
  output logic        resp_frame_err,
  output logic        busy,
  output logic        mmc_cmd_i,
  output logic        mmc_cmd_oe,
  input  logic        mmc_cmd_o
);

  localparam int CMAX_A = (NCR_MAX > FRAME_W) ? NCR_MAX : FRAME_W;
  localparam int CMAX   = (CMAX_A > NCC) ? CMAX_A : NCC;
  localparam int CW     = $clog2(CMAX + 1);

  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [PAYLOAD_W-1:0]  tx_sr;
  logic [FRAME_W-3:0]    rx_sr;   // received bits [46:1]; start bit is implicitly 0
  logic                  resp_en_q;
  logic [6:0]            tx_crc;
  logic [2:0]            crc_idx;
  logic                  tx_bit;
  logic                  accept, tx_done, start_seen, timeout, rx_done;
  logic                  crc_mismatch;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign crc_idx   = 3'(CW'(PAYLOAD_W + 6) - cnt);

  // Bit presented on the next TX tick: payload, then CRC7, then end bit
  always_comb begin
    tx_bit = 1'b1;
    if (cnt < CW'(PAYLOAD_W)) begin
      tx_bit = tx_sr[PAYLOAD_W-1];
    end else if (cnt < CW'(FRAME_W - 1)) begin
      tx_bit = tx_crc[crc_idx];
    end
  end

  // CRC is computed serially as the payload goes out, then shifted onto the line
  mmc_crc7 u_tx_crc (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    ((state == ST_TX) && mmc_tick && (cnt < CW'(PAYLOAD_W))),
    .din   (tx_bit),
    .crc   (tx_crc)
  );

`ifdef MMC_CMD_RESP_CRC_EN
  logic [6:0] rx_crc;

  mmc_crc7 u_rx_crc (
    .clk   (clk),
    .reset (reset),
    .clear (state == ST_WAIT),
    .en    ((state == ST_RX) && mmc_tick && (cnt >= CW'(8))),
    .din   (mmc_cmd_o),
    .crc   (rx_crc)
  );

  assign crc_mismatch = (rx_crc != rx_sr[6:0]);
`else
  assign crc_mismatch = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and phase-completion strobes; everything advances only on ticks
  always_comb begin
    state_n    = state;
    tx_done    = 1'b0;
    start_seen = 1'b0;
    timeout    = 1'b0;
    rx_done    = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_n = ST_TX;
      ST_TX: begin
        if (mmc_tick && (cnt == CW'(FRAME_W))) begin
          tx_done = 1'b1;
          state_n = resp_en_q ? ST_WAIT : ST_GAP;
        end
      end
      ST_WAIT: begin
        if (mmc_tick) begin
          if (!mmc_cmd_o) begin
            start_seen = 1'b1;
            state_n    = ST_RX;
          end else if (cnt == CW'(NCR_MAX - 1)) begin
            timeout = 1'b1;
            state_n = ST_GAP;
          end
        end
      end
      ST_RX: begin
        if (mmc_tick && (cnt == '0)) begin
          rx_done = 1'b1;
          state_n = ST_GAP;
        end
      end
      ST_GAP: if (mmc_tick && (cnt == CW'(NCC - 1))) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: shared tick counter, shift registers, line drive and response capture.
  // cnt counts driven bits in TX, NCR ticks in WAIT, bits remaining in RX, gap ticks in GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      tx_sr          <= '0;
      rx_sr          <= '0;
      resp_en_q      <= 1'b0;
      mmc_cmd_oe     <= 1'b0;
      mmc_cmd_i      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_index     <= '0;
      resp_data      <= '0;
      resp_timeout   <= 1'b0;
      resp_crc_err   <= 1'b0;
      resp_frame_err <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_sr     <= {1'b0, 1'b1, cmd_index, cmd_arg};
            resp_en_q <= cmd_resp_en;
            cnt       <= '0;
          end
        end
        ST_TX: begin
          if (tx_done) begin
            mmc_cmd_oe <= 1'b0;
            mmc_cmd_i  <= 1'b1;
            cnt        <= '0;
          end else if (mmc_tick) begin
            mmc_cmd_oe <= 1'b1;
            mmc_cmd_i  <= tx_bit;
            tx_sr      <= {tx_sr[PAYLOAD_W-2:0], 1'b0};
            cnt        <= cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (start_seen) begin
            cnt   <= CW'(TRANS_POS);
            rx_sr <= '0;
          end else if (timeout) begin
            resp_valid     <= 1'b1;
            resp_timeout   <= 1'b1;
            resp_crc_err   <= 1'b0;
            resp_frame_err <= 1'b0;
            cnt            <= '0;
          end else if (mmc_tick) begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RX: begin
          if (rx_done) begin
            resp_valid     <= 1'b1;
            resp_index     <= rx_sr[44:39];
            resp_data      <= rx_sr[38:7];
            resp_timeout   <= 1'b0;
            resp_crc_err   <= crc_mismatch;
            resp_frame_err <= rx_sr[TRANS_POS-CRC_LSB] | ~mmc_cmd_o;
            cnt            <= '0;
          end else if (mmc_tick) begin
            rx_sr <= {rx_sr[FRAME_W-4:0], mmc_cmd_o};
            cnt   <= cnt - CW'(1);
          end
        end
        ST_GAP: if (mmc_tick) cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule
